// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: shared state encoding and default sizes for the key session controller
package key_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, CMD, EXEC, OUT} state_t;
  localparam int PAYLOAD_W_DEF = 8;
  localparam int RES_W_DEF = 8;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/result_serializer.sv
// result_serializer: shifts a loaded result out MSB first, one bit per cycle
module result_serializer
  import key_ctrl_pkg::*;
#(
  parameter int RES_W = RES_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [RES_W-1:0] data,
  output logic             SerialOut,
  output logic             SerialOutValid,
  output logic             done
);
  localparam int CW = RES_W > 1 ? $clog2(RES_W) : 1;
  logic [RES_W-1:0] r_sh;
  logic [CW-1:0]    r_left;
  logic             r_valid;
  // shifting zeros in leaves SerialOut at 0 once the last bit has gone
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_sh    <= '0;
      r_left  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_sh    <= data;
      r_left  <= CW'(RES_W - 1);
      r_valid <= 1'b1;
    end else if (r_valid) begin
      r_sh    <= r_sh << 1;
      r_valid <= (r_left != '0);
      r_left  <= (r_left != '0) ? r_left - 1'b1 : r_left;
    end
  assign SerialOut      = r_sh[RES_W-1];
  assign SerialOutValid = r_valid;
  assign done           = r_valid && (r_left == '0);
endmodule

// File: rtl/key_session_controller.sv
// key_session_controller: collects a serial command, runs the execution unit, returns its result
module key_session_controller
  import key_ctrl_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Active,
  input  logic                 Mode,
  input  logic                 ValidCmd,
  input  logic                 InputBit,
  input  logic                 ExecDone,
  input  logic [RES_W-1:0]     ExecResult,
  output logic                 ExecStart,
  output logic [PAYLOAD_W-1:0] ExecOperand,
  output logic                 Busy,
  output logic [RES_W-1:0]     ParallelOut,
  output logic                 ParallelOutValid,
  output logic                 SerialOut,
  output logic                 SerialOutValid,
  output logic                 Error
);
  localparam int CW = PAYLOAD_W > 1 ? $clog2(PAYLOAD_W) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_BIT  = CW'(PAYLOAD_W - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
  state_t                r_state;
  logic                  r_active_q;
  logic                  r_mode;
  logic [CW-1:0]         r_cnt;
  logic [TW-1:0]         r_wait;
  logic [PAYLOAD_W-1:0]  r_payload;
  logic [RES_W-1:0]      r_pout;
  logic                  r_start;
  logic                  r_pvalid;
  logic                  r_error;
  logic                  w_ser_load;
  logic                  w_ser_done;
  assign w_ser_load = (r_state == EXEC) && ExecDone && r_mode;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      r_state    <= IDLE;
      r_active_q <= 1'b0;
      r_mode     <= 1'b0;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_payload  <= '0;
      r_pout     <= '0;
      r_start    <= 1'b0;
      r_pvalid   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_active_q <= Active;
      r_start    <= 1'b0;
      r_pvalid   <= 1'b0;
      r_error    <= 1'b0;
      case (r_state)
        IDLE: if (Active && !r_active_q) begin
          r_state   <= CMD;
          r_mode    <= Mode;
          r_cnt     <= '0;
          r_payload <= '0;
        end
        CMD: if (ValidCmd) begin
          r_payload <= {r_payload[PAYLOAD_W-2:0], InputBit};
          if (r_cnt == LAST_BIT) begin
            r_state <= EXEC;
            r_start <= 1'b1;
            r_wait  <= '0;
          end else r_cnt <= r_cnt + 1'b1;
        end else if (r_cnt != '0) begin
          r_error <= 1'b1;
          r_state <= IDLE;
        end
        // a completion on the expiry cycle is still accepted
        EXEC: if (ExecDone) begin
          r_state <= OUT;
          if (!r_mode) begin
            r_pout   <= ExecResult;
            r_pvalid <= 1'b1;
          end
        end else if (r_wait == LAST_WAIT) begin
          r_error <= 1'b1;
          r_state <= IDLE;
        end else r_wait <= r_wait + 1'b1;
        OUT: if (!r_mode || w_ser_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  result_serializer #(.RES_W(RES_W)) u_ser (
    .Clk           (Clk),
    .Reset         (Reset),
    .load          (w_ser_load),
    .data          (ExecResult),
    .SerialOut     (SerialOut),
    .SerialOutValid(SerialOutValid),
    .done          (w_ser_done)
  );
  assign Busy             = (r_state != IDLE);
  assign ExecStart        = r_start;
  assign ExecOperand      = r_payload;
  assign ParallelOut      = r_pout;
  assign ParallelOutValid = r_pvalid;
  assign Error            = r_error;
endmodule

// File: tb/tb_key_session_controller.sv
// tb_key_session_controller: directed sessions with a queue-based scoreboard on the output events
module tb_key_session_controller;
  logic       Clk = 0, Reset = 0, Active = 0, Mode = 0, ValidCmd = 0, InputBit = 0, ExecDone = 0;
  logic [7:0] ExecResult = 0;
  logic       ExecStart, Busy, ParallelOutValid, SerialOut, SerialOutValid, Error;
  logic [7:0] ExecOperand, ParallelOut;
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0;
  typedef struct {int kind; int val; int gap;} exp_t;
  exp_t q[$];

  key_session_controller #(.PAYLOAD_W(8), .RES_W(8), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .Active(Active), .Mode(Mode), .ValidCmd(ValidCmd),
    .InputBit(InputBit), .ExecDone(ExecDone), .ExecResult(ExecResult),
    .ExecStart(ExecStart), .ExecOperand(ExecOperand), .Busy(Busy),
    .ParallelOut(ParallelOut), .ParallelOutValid(ParallelOutValid),
    .SerialOut(SerialOut), .SerialOutValid(SerialOutValid), .Error(Error)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  // event kinds: 0 start(operand), 1 parallel(result), 2 serial bit, 3 error; gap -1 = any
  task automatic expect_ev(input int k, input int v, input int g);
    exp_t e;
    e.kind = k; e.val = v; e.gap = g;
    q.push_back(e);
  endtask

  task automatic expect_serial(input logic [7:0] r, input int first_gap);
    for (int i = 7; i >= 0; i--) expect_ev(2, int'(r[i]), (i == 7) ? first_gap : 1);
  endtask

  task automatic mon(input int k, input logic [31:0] v);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d val=%0h at cycle %0d", k, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || v !== e.val || (e.gap >= 0 && cyc - last_cyc != e.gap)) begin
        errors++;
        $display("FAIL event got kind=%0d val=%0h gap=%0d expected kind=%0d val=%0h gap=%0d",
                 k, v, cyc - last_cyc, e.kind, e.val, e.gap);
      end
    end
    last_cyc = cyc;
  endtask

  always @(negedge Clk) if (Reset) begin
    if (ExecStart) mon(0, 32'(ExecOperand));
    if (Error) mon(3, 0);
    if (ParallelOutValid) mon(1, 32'(ParallelOut));
    if (SerialOutValid) mon(2, 32'(SerialOut));
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(Busy), 0);
    check({tag, "_start"}, 32'(ExecStart), 0);
    check({tag, "_operand"}, 32'(ExecOperand), 0);
    check({tag, "_pout"}, 32'(ParallelOut), 0);
    check({tag, "_pvalid"}, 32'(ParallelOutValid), 0);
    check({tag, "_sout"}, 32'(SerialOut), 0);
    check({tag, "_svalid"}, 32'(SerialOutValid), 0);
    check({tag, "_error"}, 32'(Error), 0);
  endtask

  task automatic start(input logic m, input logic [7:0] p, input int nbits);
    Active = 0;
    tick;
    Active = 1;
    Mode = m;
    tick;
    for (int i = 7; i > 7 - nbits; i--) begin
      ValidCmd = 1;
      InputBit = p[i];
      tick;
    end
    ValidCmd = 0;
    InputBit = 0;
  endtask

  task automatic done_after(input int d, input logic [7:0] r);
    repeat (d) tick;
    ExecDone = 1;
    ExecResult = r;
    tick;
    ExecDone = 0;
    ExecResult = 0;
  endtask

  initial begin
    repeat (2) tick;
    check_zero("reset");
    Reset = 1;
    tick;
    // parallel session
    expect_ev(0, 8'hB3, -1);
    expect_ev(1, 8'h5A, 4);
    start(0, 8'hB3, 8);
    done_after(3, 8'h5A);
    check("par_busy_out", 32'(Busy), 1);
    tick;
    check("par_busy_idle", 32'(Busy), 0);
    check("par_hold", 32'(ParallelOut), 32'h5A);
    check("operand_hold", 32'(ExecOperand), 32'hB3);
    // reset in the middle of a payload
    start(0, 8'hA5, 4);
    check("cmd_busy", 32'(Busy), 1);
    check("cmd_partial", 32'(ExecOperand), 32'h0A);
    Reset = 0;
    Active = 0;
    #1;
    check_zero("rst_mid");
    tick;
    Reset = 1;
    repeat (3) tick;
    check("rst_release_busy", 32'(Busy), 0);
    // serial session
    expect_ev(0, 8'h0F, -1);
    expect_serial(8'hC5, 3);
    start(1, 8'h0F, 8);
    done_after(2, 8'hC5);
    repeat (8) tick;
    check("ser_busy_idle", 32'(Busy), 0);
    check("ser_valid_off", 32'(SerialOutValid), 0);
    check("ser_out_off", 32'(SerialOut), 0);
    // payload gap after 5 bits
    expect_ev(3, 0, -1);
    start(0, 8'hFF, 5);
    tick;
    check("gap_busy", 32'(Busy), 0);
    repeat (3) tick;
    // timeout with no completion
    expect_ev(0, 8'h3C, -1);
    expect_ev(3, 0, 16);
    start(0, 8'h3C, 8);
    repeat (15) tick;
    check("to_busy_last", 32'(Busy), 1);
    tick;
    check("to_busy_idle", 32'(Busy), 0);
    repeat (2) tick;
    // completion on the expiry cycle
    expect_ev(0, 8'hC3, -1);
    expect_ev(1, 8'h99, 16);
    start(0, 8'hC3, 8);
    done_after(15, 8'h99);
    tick;
    check("exp_busy_idle", 32'(Busy), 0);
    // completion on the start cycle
    expect_ev(0, 8'h01, -1);
    expect_ev(1, 8'h7E, 1);
    start(0, 8'h01, 8);
    done_after(0, 8'h7E);
    tick;
    // Active still high: no new session
    repeat (6) tick;
    check("retrig_busy", 32'(Busy), 0);
    // new edge, serial, Mode toggled during EXEC
    expect_ev(0, 8'h81, -1);
    expect_serial(8'h6E, 5);
    start(1, 8'h81, 8);
    Mode = 0;
    done_after(4, 8'h6E);
    repeat (8) tick;
    check("retrig_busy_idle", 32'(Busy), 0);
    check("retrig_pout_hold", 32'(ParallelOut), 32'h7E);
    Active = 0;
    repeat (3) tick;
    check("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
